// File: rtl/icb_pkg.sv
// Shared ICB widths and the response payload carried through the response FIFO.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package icb_pkg;

    localparam int ICB_ADDR_W = 32;
    localparam int ICB_DATA_W = 64;
    localparam int ICB_MASK_W = 8;

    // One queued response: read data (zero for writes/errors) plus error flag.
    typedef struct packed {
        logic [ICB_DATA_W-1:0] rdata;
        logic                  err;
    } icb_rsp_t;

endpackage

// File: rtl/icb_rsp_fifo.sv
// Small in-order FIFO for ICB responses; head entry reads as zero when empty.
// Latency: an entry pushed at edge N is visible at the head after edge N if the FIFO was empty.
// Backpressure: pushes while full and pops while empty are ignored; full/count let the producer stall.
module icb_rsp_fifo
    import icb_pkg::*;
#(
    parameter int  DEPTH = 2,
    parameter type T     = icb_rsp_t,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  T                 push_dat,
    input  logic             pop,
    output T                 head_dat,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    T                 slots [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH explicitly so the last slot index need not be a power-of-2 boundary.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = empty ? '0 : slots[rd_ptr];

    // Payload storage; contents need no reset because count qualifies every read.
    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            slots[wr_ptr] <= push_dat;
        end
    end

    // Pointer and occupancy tracking; simultaneous push and pop keeps count steady.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/icb_sram_responder.sv
// ICB slave backed by a 64-bit-wide on-chip memory with byte-masked writes and in-order responses.
// Latency: response valid the cycle after command accept when the response FIFO was empty.
// Backpressure: cmd_ready drops once RSP_DEPTH responses are queued; it depends only on registered state.
module icb_sram_responder
    import icb_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
    parameter int          DEPTH_WORDS = 256,
    parameter int          RSP_DEPTH   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  icb_cmd_valid,
    output logic                  icb_cmd_ready,
    input  logic [ICB_ADDR_W-1:0] icb_cmd_addr,
    input  logic                  icb_cmd_read,
    input  logic [ICB_DATA_W-1:0] icb_cmd_wdata,
    input  logic [ICB_MASK_W-1:0] icb_cmd_wmask,
    output logic                  icb_rsp_valid,
    input  logic                  icb_rsp_ready,
    output logic [ICB_DATA_W-1:0] icb_rsp_rdata,
    output logic                  icb_rsp_err
);

    localparam int              IDX_W = $clog2(DEPTH_WORDS);
    localparam int              CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [31:0]     SPAN  = 32'(DEPTH_WORDS * 8);

    logic [ICB_DATA_W-1:0] mem [DEPTH_WORDS];

    logic [ICB_ADDR_W-1:0] offset;
    logic                  dec_err;
    logic [IDX_W-1:0]      idx;
    logic                  accept;
    icb_rsp_t              rsp_new;
    icb_rsp_t              rsp_head;
    logic [CNT_W-1:0]      rsp_count;
    logic                  rsp_full;
    logic                  rsp_empty;

    // Offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
    assign offset  = icb_cmd_addr - BASE_ADDR;
    assign dec_err = (icb_cmd_addr[2:0] != 3'b000) || (offset >= SPAN);
    assign idx     = offset[IDX_W+2:3];

    // A command seen during reset is never accepted and leaves memory alone.
    assign accept = icb_cmd_valid & icb_cmd_ready & rst_n;

    // Byte-masked write; memory is written at the accept edge so a read one cycle later sees it.
    always_ff @(posedge clk) begin
        if (accept && !icb_cmd_read && !dec_err) begin
            for (int i = 0; i < ICB_MASK_W; i++) begin
                if (icb_cmd_wmask[i]) begin
                    mem[idx][8*i +: 8] <= icb_cmd_wdata[8*i +: 8];
                end
            end
        end
    end

    // Build the response captured at accept: read data, zero for writes, error with zero data.
    always_comb begin
        rsp_new = '0;
        if (dec_err) begin
            rsp_new.err = 1'b1;
        end else if (icb_cmd_read) begin
            rsp_new.rdata = mem[idx];
        end
    end

    icb_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .T     (icb_rsp_t)
    ) u_rsp_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (accept),
        .push_dat (rsp_new),
        .pop      (icb_rsp_ready),
        .head_dat (rsp_head),
        .count    (rsp_count),
        .full     (rsp_full),
        .empty    (rsp_empty)
    );

    assign icb_cmd_ready = (rsp_count < CNT_W'(RSP_DEPTH));
    assign icb_rsp_valid = ~rsp_empty;
    assign icb_rsp_rdata = rsp_head.rdata;
    assign icb_rsp_err   = rsp_head.err;

    // Ready must be the exact complement of the FIFO full flag.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (rsp_full == !icb_cmd_ready);
        end
    end

endmodule

// File: tb/tb_icb_sram_responder.sv
module tb_icb_sram_responder;
    import icb_pkg::*;

    localparam logic [31:0] BASE  = 32'h2000_0000;
    localparam int          WORDS = 256;
    localparam int          RDEP  = 2;
    localparam int          LIMIT = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        icb_cmd_valid;
    logic        icb_cmd_ready;
    logic [31:0] icb_cmd_addr;
    logic        icb_cmd_read;
    logic [63:0] icb_cmd_wdata;
    logic [7:0]  icb_cmd_wmask;
    logic        icb_rsp_valid;
    logic        icb_rsp_ready;
    logic [63:0] icb_rsp_rdata;
    logic        icb_rsp_err;

    int tests = 0;
    int fails = 0;

    icb_sram_responder #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (WORDS),
        .RSP_DEPTH   (RDEP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_cmd_wdata (icb_cmd_wdata),
        .icb_cmd_wmask (icb_cmd_wmask),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_rdata (icb_rsp_rdata),
        .icb_rsp_err   (icb_rsp_err)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [63:0] mm [int];       // word-indexed memory image
    icb_rsp_t    q[$];           // responses owed, in command order
    icb_rsp_t    log_q[$];       // responses actually consumed
    int          acc_cnt = 0;
    bit          en = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] off;
        bit          bad;
        int          w;
        bit          acc;
        bit          pop;
        icb_rsp_t    r;
        if (!rst_n) begin
            q.delete();
        end else begin
            acc = icb_cmd_valid && (q.size() < RDEP);
            pop = icb_rsp_ready && (q.size() != 0);
            if (pop) begin
                log_q.push_back(q[0]);
                void'(q.pop_front());
            end
            if (acc) begin
                acc_cnt++;
                off = icb_cmd_addr - BASE;
                bad = (icb_cmd_addr % 8 != 0) || (off >= WORDS * 8);
                w   = int'(off / 8);
                r.rdata = '0;
                r.err   = bad;
                if (!bad && icb_cmd_read) begin
                    r.rdata = mm.exists(w) ? mm[w] : 'x;
                end else if (!bad) begin
                    if (!mm.exists(w)) mm[w] = 'x;
                    for (int b = 0; b < 8; b++)
                        if (icb_cmd_wmask[b]) mm[w][8*b +: 8] = icb_cmd_wdata[8*b +: 8];
                end
                q.push_back(r);
            end
        end
    end

    // Every cycle: DUT outputs must match what the model says is owed.
    always @(negedge clk) begin
        if (en) begin
            chk("cmd_ready", icb_cmd_ready, (q.size() < RDEP));
            chk("rsp_valid", icb_rsp_valid, (q.size() != 0));
            chk("rsp_rdata", icb_rsp_rdata, (q.size() != 0) ? q[0].rdata : 64'h0);
            chk("rsp_err",   icb_rsp_err,   (q.size() != 0) ? q[0].err : 1'b0);
        end
    end

    // ---------------- driver ----------------
    // Called at negedge+1; returns at negedge+1 after the accept edge with valid dropped.
    task automatic issue(input bit rd, input logic [31:0] a, input logic [63:0] wd, input logic [7:0] wm);
        int n = 0;
        icb_cmd_valid = 1'b1;
        icb_cmd_read  = rd;
        icb_cmd_addr  = a;
        icb_cmd_wdata = wd;
        icb_cmd_wmask = wm;
        while (!icb_cmd_ready && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        chk("cmd_accept_wait", (n >= LIMIT), 1'b0);
        @(posedge clk);
        @(negedge clk); #1;
        icb_cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < LIMIT) begin
            @(negedge clk); #1;
            n++;
        end
        chk("drain", q.size(), 0);
    endtask

    logic [63:0] bp_exp [4];
    time         t0;

    initial begin
        bp_exp[0] = 64'hCAFE0000_5A5A0000;
        bp_exp[1] = 64'hCAFE0001_5A5A0001;
        bp_exp[2] = 64'hCAFE0002_5A5A0002;
        bp_exp[3] = 64'hCAFE0003_5A5A0003;

        rst_n = 1'b0; icb_cmd_valid = 1'b0; icb_rsp_ready = 1'b1;
        icb_cmd_addr = '0; icb_cmd_read = 1'b0; icb_cmd_wdata = '0; icb_cmd_wmask = '0;
        @(posedge clk); @(negedge clk); #1;
        en = 1'b1;
        chk("reset_cmd_ready", icb_cmd_ready, 1'b1);
        chk("reset_rsp_valid", icb_rsp_valid, 1'b0);
        chk("reset_rsp_rdata", icb_rsp_rdata, 64'h0);
        chk("reset_rsp_err",   icb_rsp_err,   1'b0);
        rst_n = 1'b1;
        @(negedge clk); #1;

        // full write then read, one-cycle latency
        issue(0, 32'h2000_0010, 64'h1122334455667788, 8'hFF);
        chk("wr_rsp_valid", icb_rsp_valid, 1'b1);
        chk("wr_rsp_rdata", icb_rsp_rdata, 64'h0);
        chk("wr_rsp_err",   icb_rsp_err,   1'b0);
        issue(1, 32'h2000_0010, 64'h0, 8'h00);
        chk("rd_rsp_valid", icb_rsp_valid, 1'b1);
        chk("rd_rsp_rdata", icb_rsp_rdata, 64'h1122334455667788);
        chk("rd_rsp_err",   icb_rsp_err,   1'b0);

        // partial mask merge
        issue(0, 32'h2000_0010, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        issue(1, 32'h2000_0010, 64'h0, 8'h00);
        chk("mask_rdata", icb_rsp_rdata, 64'h11223344AAAAAAAA);

        // decode errors
        issue(1, 32'h2000_0800, 64'h0, 8'h00);
        chk("oor_err",   icb_rsp_err,   1'b1);
        chk("oor_rdata", icb_rsp_rdata, 64'h0);
        issue(1, 32'h2000_0004, 64'h0, 8'h00);
        chk("mis_err",   icb_rsp_err,   1'b1);
        chk("mis_rdata", icb_rsp_rdata, 64'h0);
        issue(0, 32'h2000_0000, 64'h0123456789ABCDEF, 8'hFF);
        issue(1, 32'h2000_0000, 64'h0, 8'h00);
        chk("base_err",   icb_rsp_err,   1'b0);
        chk("base_rdata", icb_rsp_rdata, 64'h0123456789ABCDEF);

        // preload words for backpressure, then a zero-mask write
        for (int i = 0; i < 4; i++)
            issue(0, 32'h2000_0020 + 32'(8 * i), {32'hCAFE0000 + 32'(i), 32'h5A5A0000 + 32'(i)}, 8'hFF);
        issue(0, 32'h2000_0020, 64'hFFFFFFFFFFFFFFFF, 8'h00);
        chk("zmask_err", icb_rsp_err, 1'b0);
        issue(1, 32'h2000_0020, 64'h0, 8'h00);
        chk("zmask_rdata", icb_rsp_rdata, 64'hCAFE0000_5A5A0000);
        drain();

        // backpressure: only RSP_DEPTH accepted while rsp_ready is low
        icb_rsp_ready = 1'b0;
        log_q.delete();
        t0 = $time;
        acc_cnt = 0;
        issue(1, 32'h2000_0020, 64'h0, 8'h00);
        issue(1, 32'h2000_0028, 64'h0, 8'h00);
        chk("bp_ready_low", icb_cmd_ready, 1'b0);
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b1; icb_cmd_addr = 32'h2000_0030;
        repeat (3) begin @(negedge clk); #1; end
        chk("bp_accepted", acc_cnt, 2);
        icb_rsp_ready = 1'b1;
        issue(1, 32'h2000_0030, 64'h0, 8'h00);
        issue(1, 32'h2000_0038, 64'h0, 8'h00);
        drain();
        chk("bp_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk("bp_order", log_q[i].rdata, bp_exp[i]);

        // reset with two responses queued; a command during reset has no effect
        icb_rsp_ready = 1'b0;
        issue(1, 32'h2000_0010, 64'h0, 8'h00);
        issue(1, 32'h2000_0000, 64'h0, 8'h00);
        chk("pre_rst_valid", icb_rsp_valid, 1'b1);
        rst_n = 1'b0;
        icb_cmd_valid = 1'b1; icb_cmd_read = 1'b0; icb_cmd_addr = 32'h2000_0010;
        icb_cmd_wdata = 64'hFFFFFFFFFFFFFFFF; icb_cmd_wmask = 8'hFF;
        @(negedge clk); #1;
        rst_n = 1'b1; icb_cmd_valid = 1'b0;
        chk("post_rst_valid", icb_rsp_valid, 1'b0);
        chk("post_rst_ready", icb_cmd_ready, 1'b1);
        icb_rsp_ready = 1'b1;
        issue(1, 32'h2000_0010, 64'h0, 8'h00);
        chk("post_rst_rdata", icb_rsp_rdata, 64'h11223344AAAAAAAA);
        drain();

        // throughput: one command per cycle with rsp_ready high
        t0 = $time;
        for (int i = 0; i < 8; i++)
            issue(1, 32'h2000_0020 + 32'(8 * (i % 4)), 64'h0, 8'h00);
        chk("throughput_time", 64'($time - t0), 64'd80);
        drain();

        en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
